// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - walks a register range through a read port and sends each word LSB-first over a UART-style TX line
// Define REG_DUMP_CHECKSUM_EN to append a 16-bit sum word after the last register.
module reg_dump_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIRST_REG    = 0,
   parameter int LAST_REG     = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [3:0]  rd_reg,
   input  logic [15:0] rd_data,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       FIRST_IDX = 4'(FIRST_REG);
   localparam logic [3:0]       LAST_IDX  = 4'(LAST_REG);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START_BIT,
      S_DATA_BITS,
      S_STOP_BIT
`ifdef REG_DUMP_CHECKSUM_EN
      , S_SUM_PREP
`endif
   } state_t;

   state_t           state, state_nx;
   logic             done_nx;
   logic             byte_sel;
   logic [15:0]      word_buf;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       tx_byte;
   logic             bit_end;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [15:0]      sum;
   logic             sum_phase;
`endif

   assign bit_end = (clk_cnt == CNT_LAST);

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      tx       = 1'b1;
      busy     = (state != S_IDLE);
      tx_byte  = byte_sel ? word_buf[15:8] : word_buf[7:0];
      case (state)
         S_IDLE:      if (start) state_nx = S_FETCH;
         S_FETCH:     state_nx = S_START_BIT;
         S_START_BIT: begin
            tx = 1'b0;
            if (bit_end) state_nx = S_DATA_BITS;
         end
         S_DATA_BITS: begin
            tx = tx_byte[bit_idx];
            if (bit_end && bit_idx == 3'd7) state_nx = S_STOP_BIT;
         end
         S_STOP_BIT: begin
            if (bit_end) begin
               if (!byte_sel)
                  state_nx = S_START_BIT;
               else if (rd_reg < LAST_IDX)
                  state_nx = S_FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
               else if (!sum_phase)
                  state_nx = S_SUM_PREP;
`endif
               else begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
`ifdef REG_DUMP_CHECKSUM_EN
         S_SUM_PREP:  state_nx = S_START_BIT;
`endif
         default:     state_nx = S_IDLE;
      endcase
   end

   // rd_reg doubles as the word index; it only moves when a new FETCH is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         done      <= 1'b0;
         rd_reg    <= 4'd0;
         byte_sel  <= 1'b0;
         clk_cnt   <= '0;
         bit_idx   <= 3'd0;
         word_buf  <= 16'd0;
`ifdef REG_DUMP_CHECKSUM_EN
         sum       <= 16'd0;
         sum_phase <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         done  <= done_nx;
         if (state == S_START_BIT || state == S_DATA_BITS || state == S_STOP_BIT)
            clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
         else
            clk_cnt <= '0;
         if (state == S_DATA_BITS && bit_end)
            bit_idx <= bit_idx + 3'd1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  rd_reg    <= FIRST_IDX;
                  byte_sel  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                  sum       <= 16'd0;
                  sum_phase <= 1'b0;
`endif
               end
            end
            S_FETCH: begin
               word_buf <= rd_data;
`ifdef REG_DUMP_CHECKSUM_EN
               sum      <= sum + rd_data;
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_SUM_PREP: begin
               word_buf  <= sum;
               sum_phase <= 1'b1;
            end
`endif
            S_STOP_BIT: begin
               if (bit_end) begin
                  if (!byte_sel) begin
                     byte_sel <= 1'b1;
                  end else begin
                     byte_sel <= 1'b0;
                     if (rd_reg < LAST_IDX) rd_reg <= rd_reg + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb/tb_reg_dump_tx.sv - scoreboard bench for reg_dump_tx (full range and partial range instances)
module tb_reg_dump_tx;
   localparam int CPB = 4;
   localparam int PER = 1 + 20 * CPB;
`ifdef REG_DUMP_CHECKSUM_EN
   localparam int SUM_WORDS = 1;
`else
   localparam int SUM_WORDS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_cmd = 1'b0;
   logic        sel = 1'b0;
   logic        start_a, start_b;
   logic [3:0]  rd_reg_a, rd_reg_b;
   logic [15:0] rd_data_a, rd_data_b;
   logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
   logic        mon_tx, mon_busy, mon_done;
   logic [3:0]  mon_rd_reg;
   logic [15:0] regs_a [16];
   logic [15:0] regs_b [16];
   logic [7:0]  exp_q [$];
   int          abort_gen = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign start_a    = start_cmd && !sel;
   assign start_b    = start_cmd && sel;
   assign rd_data_a  = regs_a[rd_reg_a];
   assign rd_data_b  = regs_b[rd_reg_b];
   assign mon_tx     = sel ? tx_b : tx_a;
   assign mon_busy   = sel ? busy_b : busy_a;
   assign mon_done   = sel ? done_b : done_a;
   assign mon_rd_reg = sel ? rd_reg_b : rd_reg_a;

   reg_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(0), .LAST_REG(15)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .rd_reg(rd_reg_a),
      .rd_data(rd_data_a), .tx(tx_a), .busy(busy_a), .done(done_a));

   reg_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(14), .LAST_REG(15)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .rd_reg(rd_reg_b),
      .rd_data(rd_data_b), .tx(tx_b), .busy(busy_b), .done(done_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_dump(input int first, input int last);
      logic [15:0] w;
`ifdef REG_DUMP_CHECKSUM_EN
      logic [15:0] sum = 16'd0;
`endif
      for (int i = first; i <= last; i++) begin
         w = sel ? regs_b[4'(i)] : regs_a[4'(i)];
         exp_q.push_back(w[7:0]);
         exp_q.push_back(w[15:8]);
`ifdef REG_DUMP_CHECKSUM_EN
         sum = sum + w;
`endif
      end
`ifdef REG_DUMP_CHECKSUM_EN
      exp_q.push_back(sum[7:0]);
      exp_q.push_back(sum[15:8]);
`endif
   endtask

   // Called at a negedge with the selected DUT idle; returns at the done cycle.
   task automatic run_dump(input int first, input int last, input int wr_cyc, input int wr_idx,
                           input logic [15:0] wr_val, input int spur_cyc, input bit hold);
      int words, cyc, busy_n, done_n;
      bit fin;
      words = last - first + 1 + SUM_WORDS;
      push_dump(first, last);
      start_cmd = 1'b1;
      @(negedge clk);
      if (!hold) start_cmd = 1'b0;
      cyc = 0; busy_n = 0; done_n = 0; fin = 1'b0;
      check("fetch_busy", mon_busy, 1);
      check("fetch_tx_high", mon_tx, 1);
      while (!fin && cyc < words * PER + 50) begin
         if (cyc == 1) check("start_bit_low", mon_tx, 0);
         if (cyc % PER == 0 && cyc / PER <= last - first)
            check("fetch_rd_reg", mon_rd_reg, first + cyc / PER);
         if (cyc == wr_cyc) begin
            if (sel) regs_b[4'(wr_idx)] = wr_val;
            else     regs_a[4'(wr_idx)] = wr_val;
         end
         if (cyc == spur_cyc) start_cmd = 1'b1;
         else if (!hold && cyc == spur_cyc + 1) start_cmd = 1'b0;
         if (mon_busy) begin
            busy_n++;
            if (mon_done) done_n++;
         end else begin
            check("done_at_end", mon_done, 1);
            fin = 1'b1;
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("dump_finished", fin, 1);
      check("busy_cycles", busy_n, words * PER);
      check("no_early_done", done_n, 0);
      if (!hold) begin
         @(negedge clk);
         check("done_single_cycle", mon_done, 0);
         check("stays_idle", mon_busy, 0);
      end
   endtask

   always begin : rx_mon
      logic [7:0] b;
      logic       stop_b;
      int         gen;
      @(negedge clk);
      if (mon_tx === 1'b0) begin
         gen = abort_gen;
         repeat (CPB / 2) @(negedge clk);
         for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            b[j] = mon_tx;
         end
         repeat (CPB) @(negedge clk);
         stop_b = mon_tx;
         if (gen == abort_gen) begin
            check("rx_stop_bit", stop_b, 1);
            check("rx_byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("rx_byte", b, exp_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic done_seen;
      for (int i = 0; i < 16; i++) begin
         regs_a[i] = 16'hA500 | 16'(i);
         regs_b[i] = 16'h0000;
      end
      regs_b[14] = 16'h1234;
      regs_b[15] = 16'hBEEF;

      repeat (3) @(negedge clk);
      check("rst_tx", mon_tx, 1);
      check("rst_busy", mon_busy, 0);
      check("rst_done", mon_done, 0);
      check("rst_rd_reg", mon_rd_reg, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Full dump; reg3 overwritten during its DATA_BITS, stray start while busy.
      run_dump(0, 15, 3 * PER + 1 + CPB + 2, 3, 16'hFFFF, 600, 1'b0);
      regs_a[3] = 16'hA503;
      repeat (5) @(negedge clk);

      // Abort during bit 4 of the second word's low byte.
      push_dump(0, 15);
      start_cmd = 1'b1;
      @(negedge clk);
      start_cmd = 1'b0;
      repeat (PER + 1 + CPB + 4 * CPB + 1) @(negedge clk);
      rst = 1'b1;
      abort_gen++;
      exp_q.delete();
      #1;
      check("abort_tx", mon_tx, 1);
      check("abort_busy", mon_busy, 0);
      check("abort_done", mon_done, 0);
      repeat (12) @(negedge clk);
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         done_seen = done_seen | mon_done;
      end
      check("no_done_after_abort", done_seen, 0);
      run_dump(0, 15, -1, 0, 16'h0, -1, 1'b0);
      repeat (5) @(negedge clk);

      // Start held high: second dump's FETCH directly after the done cycle.
      run_dump(0, 15, -1, 0, 16'h0, -1, 1'b1);
      run_dump(0, 15, -1, 0, 16'h0, -1, 1'b0);
      repeat (5) @(negedge clk);

      sel = 1'b1;
      repeat (2) @(negedge clk);
      run_dump(14, 15, -1, 0, 16'h0, -1, 1'b0);

      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
      check("rx_queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Register-file dump transmitter for the 16×16-bit CPU register bank. On a start request it walks a parameterised range of register indices through one of the register file's combinational read ports and captures each 16-bit value. It then serialises each value onto a UART-style TX line, low byte first. It sits beside the register file on the debug/observability path, drives a read address into the register file, and drives the board's serial output pin.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit (≥2)
- FIRST_REG, 0, first register index dumped (0–15)
- LAST_REG, 15, last register index dumped (FIRST_REG ≤ LAST_REG ≤ 15)
- clk  input  1  single clock, all state on posedge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  dump request, sampled only in IDLE
- rd_reg  output  4  read address to the register file's read port
- rd_data  input  16  combinational read data from the register file
- tx  output  1  serial line, idle high
- busy  output  1  high while a dump is in progress
- done  output  1  one-cycle pulse when a dump completes

## Operation
- States: IDLE, FETCH, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: tx=1, busy=0. If start=1 at a posedge, set the index to FIRST_REG, set byte_sel=low, and go to FETCH.
- FETCH (1 cycle): rd_reg=index. At the end of the cycle, capture rd_data into the 16-bit word buffer, then go to START_BIT.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits of the selected byte, LSB first, each held CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then:
  - If byte_sel=low: set byte_sel=high and go to START_BIT.
  - Else if index<LAST_REG: increment index, set byte_sel=low, and go to FETCH.
  - Else: go to IDLE with done=1 for that first IDLE cycle.
- Frame per byte: 1 start, 8 data, 1 stop, no parity.
- Register writes occur on negedge clk. The captured value is whatever rd_data shows at the FETCH posedge. Later writes to that register do not alter the word in flight.
- start while busy is ignored. No queueing.
- start held high: the done/IDLE cycle accepts it, so a new dump begins the following cycle.
- rd_reg holds its last value outside FETCH. Only the FETCH-cycle value is meaningful.

## Timing
- Reset values: tx=1, busy=0, done=0, rd_reg=4'd0, state=IDLE, bit/cycle counters=0, word buffer=0.
- rst is asynchronous. Asserting it mid-dump forces all reset values immediately and aborts the frame; tx returns high within the same cycle. No done pulse is produced.
- start sampled at posedge N. busy=1 and FETCH occupy cycle N+1. tx falls at cycle N+2.
- Per word: 1 + 20·CLKS_PER_BIT cycles.
- Words = LAST_REG−FIRST_REG+1 (+1 with the checksum option).
- busy stays high for words·(1+20·CLKS_PER_BIT) cycles exactly.
- done is asserted in the cycle busy first reads 0.
- The bit counter wraps at CLKS_PER_BIT−1. The data-bit index wraps at 7. Index arithmetic is 4-bit and never exceeds LAST_REG.

## Configuration
- REG_DUMP_CHECKSUM_EN defined:
  - After LAST_REG, send one extra word: the 16-bit sum, modulo 2^16, of all dumped words.
  - It is preceded by a 1-cycle prep state in place of FETCH (rd_reg unchanged) and sent low byte first.
  - The accumulator clears when start is accepted and on rst.
- Not defined: exactly LAST_REG−FIRST_REG+1 words. No accumulator logic is present.

## Test plan
- Full dump, checksum off:
  - Stimulus: CLKS_PER_BIT=4, reg i preloaded to 16'hA500|i, single start pulse.
  - Required response: tx bytes 00,A5,01,A5,…,0F,A5; busy high exactly 1296 cycles; one done pulse.
- Checksum on, same stimulus:
  - Required response: 16 words then bytes 78,50 (sum 16'h5078); busy exactly 1377 cycles.
- Partial range:
  - Stimulus: FIRST_REG=14, LAST_REG=15, reg14=16'h1234, reg15=16'hBEEF.
  - Required response: bytes 34,12,EF,BE; rd_reg equals 14 then 15 in the respective FETCH cycles.
- Mid-dump write:
  - Stimulus: write reg3=16'hFFFF on the negedge during reg3's DATA_BITS.
  - Required response: transmitted reg3 is the pre-write value 16'hA503.
- Reset and start handling:
  - Stimulus: assert rst during the 5th data bit of word 2.
  - Required response: tx=1, busy=0, done=0 immediately.
  - Stimulus: a start pulse 10 cycles later.
  - Required response: restarts from FIRST_REG. A start pulsed while busy has no effect.
- Back-to-back:
  - Stimulus: start held high continuously.
  - Required response: second dump's FETCH follows the done cycle directly; exactly 1 IDLE cycle between dumps.
